// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: defaults, FSM states, window check.
// Latency: n/a (package).
// Backpressure: n/a (package).
package loader_pkg;

    localparam logic [15:0] BASE_ADDR_DEF   = 16'hC000;
    localparam int          MEM_DEPTH_DEF   = 16384;
    localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
    localparam int          TIMEOUT_CYC_DEF = 5_000_000;

    // Program-memory byte offset width
    localparam int          ADDR_W          = 14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        LEN_HI  = 3'd3,
        LEN_LO  = 3'd4,
        DATA    = 3'd5,
        CHECK   = 3'd6
    } loader_state_t;

    // True when [start, start+len-1] lies inside [base, last]. Done in 17 bits so
    // a frame running past 0xFFFF is caught rather than wrapping to a low address.
    function automatic logic in_window(input logic [15:0] start,
                                       input logic [15:0] len,
                                       input logic [15:0] base,
                                       input logic [16:0] last);
        logic [16:0] frame_last;
        frame_last = {1'b0, start} + {1'b0, len} - 17'd1;
        return ({1'b0, start} >= {1'b0, base}) && (frame_last <= last);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in / program-memory write port and status out of the program loader.
// Latency: n/a (wiring only).
// Backpressure: none; the receive side is a bare valid strobe.
interface program_loader_if;
    import loader_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;

    // Host side: UART receiver feeding bytes, observing memory writes and status
    modport master (
        output rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );

endinterface

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: flags TIMEOUT_CYC consecutive enabled cycles without a kick.
// Latency: expired is combinational on the TIMEOUT_CYC-th quiet cycle.
// Backpressure: none.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic kick,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] cnt;

    // cnt holds the number of quiet cycles already elapsed; a kick always wins
    assign expired = enable && !kick && (cnt == CW'(TIMEOUT_CYC - 1));

    // Count quiet cycles while enabled; reload on kick, idle or expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (kick || !enable || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Parses framed bytes from the UART and writes the payload into 6502 program memory.
// Latency: each data byte is written one cycle after its rx_valid; load_done one cycle after CHK.
// Backpressure: none; every rx_valid is consumed, back-to-back bytes included.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave bus
);
    localparam logic [16:0] WINDOW_LAST = 17'(int'(BASE_ADDR) + MEM_DEPTH - 1);

    loader_state_t     state, state_n;
    logic [7:0]        addr_hi_q, addr_lo_q, len_hi_q, csum_q;
    logic [15:0]       remain_q;
    logic [ADDR_W-1:0] ptr_q, mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q, load_done_q, load_error_q, released_q;

    logic [15:0]       start_word, len_word;
    logic              range_ok, tmo_en, tmo_expired;
    logic              frame_start, frame_ok, frame_bad, data_open, data_write;

    assign start_word = {addr_hi_q, addr_lo_q};
    // Only meaningful in LEN_LO, where rx_data carries the low length byte
    assign len_word   = {len_hi_q, bus.rx_data};
    assign range_ok   = in_window(start_word, len_word, BASE_ADDR, WINDOW_LAST);
    assign tmo_en     = (state != IDLE);

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .kick    (bus.rx_valid),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-byte control strobes
    always_comb begin
        state_n     = state;
        frame_start = 1'b0;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        data_open   = 1'b0;
        data_write  = 1'b0;
        if (bus.rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_n     = ADDR_HI;
                        frame_start = 1'b1;
                    end
                end
                ADDR_HI: state_n = ADDR_LO;
                ADDR_LO: state_n = LEN_HI;
                LEN_HI:  state_n = LEN_LO;
                LEN_LO: begin
                    if (!range_ok) begin
                        state_n   = IDLE;
                        frame_bad = 1'b1;
                    end else if (len_word == 16'd0) begin
                        state_n   = CHECK;
                    end else begin
                        state_n   = DATA;
                        data_open = 1'b1;
                    end
                end
                DATA: begin
                    data_write = 1'b1;
                    if (remain_q == 16'd1) begin
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    state_n = IDLE;
                    if (8'(csum_q + bus.rx_data) == 8'h00) begin
                        frame_ok  = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (tmo_expired) begin
            state_n   = IDLE;
            frame_bad = 1'b1;
        end
    end

    // Header capture, running checksum and payload write pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_hi_q <= '0;
            addr_lo_q <= '0;
            len_hi_q  <= '0;
            csum_q    <= '0;
            remain_q  <= '0;
            ptr_q     <= '0;
        end else begin
            if (bus.rx_valid && state == ADDR_HI) addr_hi_q <= bus.rx_data;
            if (bus.rx_valid && state == ADDR_LO) addr_lo_q <= bus.rx_data;
            if (bus.rx_valid && state == LEN_HI)  len_hi_q  <= bus.rx_data;
            if (frame_start) begin
                csum_q <= '0;
            end else if (bus.rx_valid && state != IDLE && state != CHECK) begin
                csum_q <= csum_q + bus.rx_data;
            end
            if (data_open) begin
                ptr_q    <= ADDR_W'(start_word - BASE_ADDR);
                remain_q <= len_word;
            end else if (data_write) begin
                ptr_q    <= ptr_q + ADDR_W'(1);
                remain_q <= remain_q - 16'd1;
            end
        end
    end

    // Memory write port and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            released_q   <= 1'b0;
        end else begin
            mem_we_q    <= data_write;
            load_done_q <= frame_ok;
            if (data_write) begin
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= bus.rx_data;
            end
            if (frame_start) begin
                load_error_q <= 1'b0;
            end else if (frame_bad) begin
                load_error_q <= 1'b1;
            end
            // Released off the done pulse so the CPU leaves reset the cycle after it
            if (load_done_q) begin
                released_q <= 1'b1;
            end
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;
    assign bus.cpu_hold   = !released_q || (state != IDLE);

endmodule
